// File: rtl/rs_allocator_pkg.sv
// Shared types for the reservation-station allocator: operation, functional-unit
// select, issue broadcast and RS id.
package rs_allocator_pkg;

    localparam int NUM_RS = 8;

    typedef logic [2:0] rs_id_t;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_BU   = 2'd1,
        FU_LSU  = 2'd2,
        FU_NONE = 2'd3
    } e_functional_unit;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } operation_specification;

    typedef struct packed {
        logic                   valid;
        rs_id_t                 rs_id;
        operation_specification op;
    } issue_bus;

    function automatic logic [3:0] popcount8(input logic [NUM_RS-1:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rs_lowest_free.sv
// Priority encoder: returns the index of the lowest set bit of the free mask.
module rs_lowest_free
    import rs_allocator_pkg::*;
(
    input  logic [NUM_RS-1:0] i_free_mask,
    output rs_id_t            o_id,
    output logic              o_found
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_id    = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (i_free_mask[i]) begin
                o_found = 1'b1;
                o_id    = rs_id_t'(i);
            end
        end
    end

endmodule

// File: rtl/rs_allocator.sv
// Reservation-station allocator: picks the lowest free entry in the target
// unit's partition, tracks busy/occupancy, and broadcasts a registered issue.
module rs_allocator
    import rs_allocator_pkg::*;
#(
    parameter int ALU_SLOTS = 4,
    parameter int BU_SLOTS  = 2,
    parameter int LSU_SLOTS = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  operation_specification i_in_op,
    input  e_functional_unit       i_in_fu,
    output issue_bus               o_issue,
    input  logic                   i_free_valid,
    input  rs_id_t                 i_free_id,
    input  logic                   i_flush,
    output logic [NUM_RS-1:0]      o_busy_mask,
    output logic [3:0]             o_occupancy,
    output logic                   o_free_err
);

    if (ALU_SLOTS + BU_SLOTS + LSU_SLOTS != NUM_RS) begin : g_bad_partition
        $error("rs_allocator: partition sizes must sum to NUM_RS");
    end

    localparam logic [NUM_RS-1:0] ALU_MASK = NUM_RS'((1 << ALU_SLOTS) - 1);
    localparam logic [NUM_RS-1:0] BU_MASK  = NUM_RS'(((1 << BU_SLOTS) - 1) << ALU_SLOTS);
    localparam logic [NUM_RS-1:0] LSU_MASK = NUM_RS'(((1 << LSU_SLOTS) - 1) << (ALU_SLOTS + BU_SLOTS));

    logic [NUM_RS-1:0] r_busy;
    logic [3:0]        r_occupancy;
    logic              r_free_err;
    issue_bus          r_issue;

    logic [NUM_RS-1:0] w_part_mask;
    logic [NUM_RS-1:0] w_free_mask;
    logic [NUM_RS-1:0] w_busy_next;
    rs_id_t            w_sel_id;
    logic              w_found;
    logic              w_accept;
    logic              w_free_hit;
    logic              w_free_bad;

    always_comb begin
        w_part_mask = '0;
        case (i_in_fu)
            FU_ALU:  w_part_mask = ALU_MASK;
            FU_BU:   w_part_mask = BU_MASK;
            FU_LSU:  w_part_mask = LSU_MASK;
            default: w_part_mask = '0;
        endcase
    end

    assign w_free_mask = ~r_busy & w_part_mask;

    rs_lowest_free u_lowest_free (
        .i_free_mask (w_free_mask),
        .o_id        (w_sel_id),
        .o_found     (w_found)
    );

    assign o_in_ready = w_found & ~i_flush;
    assign w_accept   = i_in_valid & o_in_ready;

    // Flush wins over a concurrent free, including its error detection.
    assign w_free_hit = i_free_valid & ~i_flush &  r_busy[i_free_id];
    assign w_free_bad = i_free_valid & ~i_flush & ~r_busy[i_free_id];

    always_comb begin
        w_busy_next = r_busy;
        if (i_flush) begin
            w_busy_next = '0;
        end else begin
            if (w_free_hit) begin
                w_busy_next[i_free_id] = 1'b0;
            end
            if (w_accept) begin
                w_busy_next[w_sel_id] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy      <= '0;
            r_occupancy <= '0;
            r_free_err  <= 1'b0;
            r_issue     <= '0;
        end else begin
            r_busy        <= w_busy_next;
            r_occupancy   <= popcount8(w_busy_next);
            r_issue.valid <= w_accept;
            if (w_free_bad) begin
                r_free_err <= 1'b1;
            end
            if (w_accept) begin
                r_issue.rs_id <= w_sel_id;
                r_issue.op    <= i_in_op;
            end
        end
    end

    assign o_busy_mask = r_busy;
    assign o_occupancy = r_occupancy;
    assign o_free_err  = r_free_err;
    assign o_issue     = r_issue;

endmodule

// File: doc/rs_allocator.md
RS_ALLOCATOR -- requirements
Module: rs_allocator

Interface
REQ-001 Parameter ALU_SLOTS, default 4, reservation-station entries owned by ALU (ids 0..ALU_SLOTS-1).
REQ-002 Parameter BU_SLOTS, default 2, entries owned by BU (ids following ALU block).
REQ-003 Parameter LSU_SLOTS, default 2, entries owned by LSU (ids following BU block); ALU_SLOTS+BU_SLOTS+LSU_SLOTS SHALL equal 8.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  decoded operation offered.
REQ-007 in_ready  out  1  allocator accepts offered operation this cycle.
REQ-008 in_op  in  operation_specification  decoded operation.
REQ-009 in_fu  in  e_functional_unit  target unit of in_op.
REQ-010 issue  out  issue_bus  registered issue broadcast (valid, rs_id, op).
REQ-011 free_valid  in  1  an RS entry completed this cycle.
REQ-012 free_id  in  3  id of completed entry.
REQ-013 flush  in  1  squash all entries (mispredict/exception).
REQ-014 busy_mask  out  8  bit i set = entry i allocated.
REQ-015 occupancy  out  4  popcount of busy_mask, 0..8.
REQ-016 free_err  out  1  sticky: free of a non-busy entry seen.

Function
REQ-017 Accept = in_valid & in_ready, sampled on rising clk.
REQ-018 in_ready SHALL be 1 iff flush=0 and the partition selected by in_fu holds at least one clear busy bit; combinational from in_fu, flush, busy register only (independent of in_valid).
REQ-019 On accept, the lowest-numbered free id in the in_fu partition SHALL be chosen and its busy bit set at that edge.
REQ-020 issue.valid SHALL be 1 for exactly the cycle after each accept, carrying the chosen rs_id and in_op captured at the accept edge; otherwise issue.valid=0, rs_id and op hold last values.
REQ-021 Latency offer->issue: 1 cycle; sustained throughput 1 op/cycle while slots remain.
REQ-022 On free_valid with busy[free_id]=1, that bit SHALL clear at the edge.
REQ-023 On free_valid with busy[free_id]=0, busy unchanged and free_err set (cleared only by reset).
REQ-024 Free and allocate in same cycle: both applied; a freed id is not visible to in_ready/selection until the next cycle (no bypass).
REQ-025 Free and allocate naming the same id in one cycle cannot occur (id was busy); no special case.
REQ-026 Partition full: in_ready=0, offered op held by upstream, no state change.
REQ-027 flush=1: all busy bits clear at the edge, no accept, issue.valid=0 next cycle; a concurrent free_valid is ignored and does not set free_err.
REQ-028 occupancy SHALL equal popcount(busy_mask) every cycle, registered alongside busy.

Reset
REQ-029 rst_n=0 asynchronously: busy_mask=0, occupancy=0, issue.valid=0, issue.rs_id=0, issue.op all-zero, free_err=0.
REQ-030 Reset mid-operation discards all in-flight allocations; first accept after deassertion yields rs_id 0 for ALU.
REQ-031 Outputs valid from first rising edge after rst_n deasserts.

Structure
REQ-032 NUM_RS=8 and rs_id typedef (3 bits) SHALL be added to package types; partition parameters stay local to the module.
REQ-033 One sub-module, rs_lowest_free (masked lowest-set-bit priority encoder returning id and found flag), SHALL perform slot selection.

Verification
REQ-034 Reset then ALU ops on 5 consecutive cycles -> issue rs_id 0,1,2,3 on cycles 2..5; fifth op sees in_ready=0, occupancy=4.
REQ-035 BU op, LSU op, BU op back-to-back -> rs_id 4, 6, 5; busy_mask=8'b0111_0000.
REQ-036 ALU full, free_id=2 with ALU offer same cycle -> no accept that cycle; next cycle accept, issue rs_id 2.
REQ-037 free_valid with free_id=7 while idle -> free_err=1, busy_mask unchanged, remains 1 after further traffic.
REQ-038 occupancy=6, flush with in_valid=1 -> in_ready=0, next cycle busy_mask=0, occupancy=0, issue.valid=0.
REQ-039 rst_n pulsed low between clock edges with occupancy=3 -> outputs zero immediately, before the next edge.
